// File: rtl/alsu_param_if.sv
// ALSU bus: operands, op controls and qualifier in; result, valid, error, LEDs out.
// master drives operands/controls; slave (the ALSU) drives OUT/OUT_VALID/ERR/LEDS.
interface alsu_param_if #(
  parameter int WIDTH     = 3,
  parameter int LED_WIDTH = 16
);
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2:0]           OPCODE;
  logic                 CIN;
  logic                 SERIAL_IN;
  logic                 DIRECTION;
  logic                 RED_OP_A;
  logic                 RED_OP_B;
  logic                 BYPASSA;
  logic                 BYPASSB;
  logic                 IN_VALID;
  logic [2*WIDTH-1:0]   OUT;
  logic                 OUT_VALID;
  logic                 ERR;
  logic [LED_WIDTH-1:0] LEDS;

  modport master (
    output A, B, OPCODE, CIN, SERIAL_IN, DIRECTION,
    output RED_OP_A, RED_OP_B, BYPASSA, BYPASSB, IN_VALID,
    input  OUT, OUT_VALID, ERR, LEDS
  );

  modport slave (
    input  A, B, OPCODE, CIN, SERIAL_IN, DIRECTION,
    input  RED_OP_A, RED_OP_B, BYPASSA, BYPASSB, IN_VALID,
    output OUT, OUT_VALID, ERR, LEDS
  );
endinterface

// File: rtl/alsu_param.sv
// Two-stage ALSU: stage 1 registers all inputs, stage 2 computes OUT/ERR/LEDS.
// Ports: clk, rst (async, active-high), bus (alsu_param_if.slave).
module alsu_param #(
  parameter int          WIDTH          = 3,
  parameter logic [7:0]  INPUT_PRIORITY = "A",
  parameter logic [23:0] FULL_ADDER     = "ON",
  parameter int          LED_WIDTH      = 16
) (
  input logic         clk,
  input logic         rst,
  alsu_param_if.slave bus
);

  localparam int          OW     = 2 * WIDTH;
  localparam logic [7:0]  PRI_A  = "A";
  localparam logic [23:0] FA_ON  = "ON";
  localparam bit          PRI_IS_A = (INPUT_PRIORITY == PRI_A);
  localparam bit          USE_CIN  = (FULL_ADDER == FA_ON);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             cin;
    logic             sin;
    logic             dir;
    logic             roa;
    logic             rob;
    logic             bpa;
    logic             bpb;
    logic             vld;
  } s1_t;

  s1_t s1_d, s1_q;

  logic [OW-1:0]        out_d, out_q;
  logic                 ovld_d, ovld_q;
  logic                 err_d, err_q;
  logic [LED_WIDTH-1:0] leds_d, leds_q;

  always_comb begin
    s1_d     = '0;
    s1_d.a   = bus.A;
    s1_d.b   = bus.B;
    s1_d.op  = bus.OPCODE;
    s1_d.cin = bus.CIN;
    s1_d.sin = bus.SERIAL_IN;
    s1_d.dir = bus.DIRECTION;
    s1_d.roa = bus.RED_OP_A;
    s1_d.rob = bus.RED_OP_B;
    s1_d.bpa = bus.BYPASSA;
    s1_d.bpb = bus.BYPASSB;
    s1_d.vld = bus.IN_VALID;
  end

  logic             invalid;
  logic             red;
  logic             red_a;
  logic             byp;
  logic             byp_a;
  logic [WIDTH-1:0] red_v;
  logic [WIDTH-1:0] byp_v;
  logic [OW-1:0]    a_x, b_x, cin_x;

  // Reductions are only defined for opcodes 0/1.
  assign red     = s1_q.roa | s1_q.rob;
  assign invalid = (s1_q.op[2:1] == 2'b11)
                 | (red & (s1_q.op[2:1] != 2'b00));

  // Tie between A/B selects resolved by INPUT_PRIORITY.
  assign red_a = s1_q.roa & (~s1_q.rob | PRI_IS_A);
  assign red_v = red_a ? s1_q.a : s1_q.b;
  assign byp   = s1_q.bpa | s1_q.bpb;
  assign byp_a = s1_q.bpa & (~s1_q.bpb | PRI_IS_A);
  assign byp_v = byp_a ? s1_q.a : s1_q.b;

  assign a_x   = OW'(s1_q.a);
  assign b_x   = OW'(s1_q.b);
  assign cin_x = OW'(s1_q.cin & USE_CIN);

  always_comb begin
    out_d  = out_q;
    ovld_d = 1'b0;
    err_d  = err_q;
    leds_d = leds_q;
    if (s1_q.vld) begin
      ovld_d = 1'b1;
      if (invalid) begin
        out_d  = '0;
        err_d  = 1'b1;
        leds_d = ~leds_q;
      end else begin
        err_d  = 1'b0;
        leds_d = '0;
        if (byp) begin
          out_d = OW'(byp_v);
        end else begin
          case (s1_q.op)
            3'd0: out_d = red ? OW'(&red_v)
                              : OW'(s1_q.a & s1_q.b);
            3'd1: out_d = red ? OW'(^red_v)
                              : OW'(s1_q.a ^ s1_q.b);
            3'd2: out_d = a_x + b_x + cin_x;
            3'd3: out_d = a_x * b_x;
            3'd4: out_d = s1_q.dir
                        ? {out_q[OW-2:0], s1_q.sin}
                        : {s1_q.sin, out_q[OW-1:1]};
            3'd5: out_d = s1_q.dir
                        ? {out_q[OW-2:0], out_q[OW-1]}
                        : {out_q[0], out_q[OW-1:1]};
            default: out_d = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      out_q  <= '0;
      ovld_q <= 1'b0;
      err_q  <= 1'b0;
      leds_q <= '0;
    end else begin
      s1_q   <= s1_d;
      out_q  <= out_d;
      ovld_q <= ovld_d;
      err_q  <= err_d;
      leds_q <= leds_d;
    end
  end

  assign bus.OUT       = out_q;
  assign bus.OUT_VALID = ovld_q;
  assign bus.ERR       = err_q;
  assign bus.LEDS      = leds_q;

endmodule

// File: tb/tb_alsu_param.sv
// Directed bench for alsu_param: defaults, INPUT_PRIORITY="B", FULL_ADDER="OFF".
// ia drives all three instances; expected values are hand-computed constants.
module tb_alsu_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alsu_param_if #(.WIDTH(3), .LED_WIDTH(16)) ia ();
  alsu_param_if #(.WIDTH(3), .LED_WIDTH(16)) ib ();
  alsu_param_if #(.WIDTH(3), .LED_WIDTH(16)) ic ();

  assign ib.A = ia.A;                 assign ic.A = ia.A;
  assign ib.B = ia.B;                 assign ic.B = ia.B;
  assign ib.OPCODE = ia.OPCODE;       assign ic.OPCODE = ia.OPCODE;
  assign ib.CIN = ia.CIN;             assign ic.CIN = ia.CIN;
  assign ib.SERIAL_IN = ia.SERIAL_IN; assign ic.SERIAL_IN = ia.SERIAL_IN;
  assign ib.DIRECTION = ia.DIRECTION; assign ic.DIRECTION = ia.DIRECTION;
  assign ib.RED_OP_A = ia.RED_OP_A;   assign ic.RED_OP_A = ia.RED_OP_A;
  assign ib.RED_OP_B = ia.RED_OP_B;   assign ic.RED_OP_B = ia.RED_OP_B;
  assign ib.BYPASSA = ia.BYPASSA;     assign ic.BYPASSA = ia.BYPASSA;
  assign ib.BYPASSB = ia.BYPASSB;     assign ic.BYPASSB = ia.BYPASSB;
  assign ib.IN_VALID = ia.IN_VALID;   assign ic.IN_VALID = ia.IN_VALID;

  alsu_param #(.WIDTH(3)) u0 (
    .clk(clk), .rst(rst), .bus(ia)
  );
  alsu_param #(.WIDTH(3), .INPUT_PRIORITY("B")) ub (
    .clk(clk), .rst(rst), .bus(ib)
  );
  alsu_param #(.WIDTH(3), .FULL_ADDER("OFF")) uc (
    .clk(clk), .rst(rst), .bus(ic)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op,
                       input logic [2:0] a, input logic [2:0] b,
                       input logic cin, input logic si,
                       input logic dir, input logic roa,
                       input logic rob, input logic bpa,
                       input logic bpb);
    ia.OPCODE = op;
    ia.A = a;
    ia.B = b;
    ia.CIN = cin;
    ia.SERIAL_IN = si;
    ia.DIRECTION = dir;
    ia.RED_OP_A = roa;
    ia.RED_OP_B = rob;
    ia.BYPASSA = bpa;
    ia.BYPASSB = bpb;
    ia.IN_VALID = 1'b1;
  endtask

  task automatic run();
    tick();
    ia.IN_VALID = 1'b0;
    tick();
  endtask

  initial begin
    drive(3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    ia.IN_VALID = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out", ia.OUT, 0);
    chk("rst_ovld", ia.OUT_VALID, 0);
    chk("rst_err", ia.ERR, 0);
    chk("rst_leds", ia.LEDS, 0);
    tick();
    tick();
    rst = 1'b0;

    drive(3'd2, 3'd5, 3'd3, 1, 0, 0, 0, 0, 0, 0);
    run();
    chk("add_out", ia.OUT, 9);
    chk("add_ovld", ia.OUT_VALID, 1);
    chk("add_err", ia.ERR, 0);
    chk("add_nocin", ic.OUT, 8);
    tick();
    chk("idle_ovld", ia.OUT_VALID, 0);
    chk("idle_hold", ia.OUT, 9);

    drive(3'd3, 3'd7, 3'd7, 0, 0, 0, 0, 0, 0, 0);
    run();
    chk("mul77", ia.OUT, 49);

    drive(3'd1, 3'd6, 3'd0, 0, 0, 0, 1, 0, 0, 0);
    run();
    chk("redxor_a6", ia.OUT, 0);
    drive(3'd1, 3'd7, 3'd0, 0, 0, 0, 1, 0, 0, 0);
    run();
    chk("redxor_a7", ia.OUT, 1);
    drive(3'd0, 3'd6, 3'd3, 0, 0, 0, 0, 0, 0, 0);
    run();
    chk("and_bit", ia.OUT, 2);
    drive(3'd0, 3'd7, 3'd3, 0, 0, 0, 0, 1, 0, 0);
    run();
    chk("redand_b", ia.OUT, 0);
    drive(3'd0, 3'd7, 3'd3, 0, 0, 0, 1, 1, 0, 0);
    run();
    chk("redand_pa", ia.OUT, 1);
    chk("redand_pb", ib.OUT, 0);
    drive(3'd1, 3'd6, 3'd3, 0, 0, 0, 0, 0, 0, 0);
    run();
    chk("xor_bit", ia.OUT, 5);

    drive(3'd6, 3'd1, 3'd1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("blink1_out", ia.OUT, 0);
    chk("blink1_err", ia.ERR, 1);
    chk("blink1_led", ia.LEDS, 16'hffff);
    tick();
    chk("blink2_err", ia.ERR, 1);
    chk("blink2_led", ia.LEDS, 16'h0000);
    drive(3'd2, 3'd1, 3'd1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("blink3_led", ia.LEDS, 16'hffff);
    ia.IN_VALID = 1'b0;
    tick();
    chk("clr_led", ia.LEDS, 0);
    chk("clr_err", ia.ERR, 0);
    chk("clr_out", ia.OUT, 2);

    drive(3'd2, 3'd5, 3'd1, 0, 0, 0, 1, 0, 1, 0);
    run();
    chk("redinv_out", ia.OUT, 0);
    chk("redinv_err", ia.ERR, 1);
    chk("redinv_led", ia.LEDS, 16'hffff);

    drive(3'd3, 3'd2, 3'd5, 0, 0, 0, 0, 0, 1, 1);
    run();
    chk("byp_pa", ia.OUT, 2);
    chk("byp_pb", ib.OUT, 5);
    chk("byp_err", ia.ERR, 0);
    chk("byp_led", ia.LEDS, 0);
    drive(3'd2, 3'd1, 3'd6, 0, 0, 0, 0, 0, 0, 1);
    run();
    chk("byp_b", ia.OUT, 6);

    drive(3'd0, 3'd3, 3'd0, 0, 0, 0, 0, 0, 1, 0);
    run();
    chk("seed3", ia.OUT, 3);
    drive(3'd5, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(3'd5, 3'd0, 3'd0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    chk("rot_r", ia.OUT, 6'b100001);
    drive(3'd4, 3'd0, 3'd0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    chk("rot_l", ia.OUT, 6'b000011);
    drive(3'd4, 3'd0, 3'd0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    chk("shr_si1", ia.OUT, 6'b100001);
    ia.IN_VALID = 1'b0;
    tick();
    chk("shl_si0", ia.OUT, 6'b000010);

    drive(3'd7, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    run();
    chk("op7_err", ia.ERR, 1);
    drive(3'd2, 3'd3, 3'd4, 0, 0, 0, 0, 0, 0, 0);
    tick();
    ia.IN_VALID = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_out", ia.OUT, 0);
    chk("mrst_ovld", ia.OUT_VALID, 0);
    chk("mrst_err", ia.ERR, 0);
    chk("mrst_leds", ia.LEDS, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_ovld", ia.OUT_VALID, 0);
      chk("post_out", ia.OUT, 0);
    end

    drive(3'd2, 3'd5, 3'd3, 0, 0, 0, 0, 0, 0, 0);
    run();
    chk("recov_out", ia.OUT, 8);
    chk("recov_ovld", ia.OUT_VALID, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alsu_param.md
ALSU_PARAM -- requirements
Module: alsu_param

Interface
REQ-001 Parameter WIDTH, default 3, operand width A/B; legal range 2..16.
REQ-002 Parameter INPUT_PRIORITY, default "A", operand chosen when both A-side and B-side selects are set; legal "A" or "B".
REQ-003 Parameter FULL_ADDER, default "ON"; "ON" adds CIN, "OFF" ignores CIN.
REQ-004 Parameter LED_WIDTH, default 16, width of LEDS.
REQ-005 Ports:
 - clk  input  1  single clock, all state on rising edge
 - rst  input  1  reset; asynchronous and active-high
 - A  input  WIDTH  operand A
 - B  input  WIDTH  operand B
 - OPCODE  input  3  operation select
 - CIN  input  1  adder carry-in
 - SERIAL_IN  input  1  fill bit for shift
 - DIRECTION  input  1  1 = left, 0 = right
 - RED_OP_A  input  1  reduction on A
 - RED_OP_B  input  1  reduction on B
 - BYPASSA  input  1  pass A to OUT
 - BYPASSB  input  1  pass B to OUT
 - IN_VALID  input  1  inputs qualified this cycle
 - OUT  output  2*WIDTH  result
 - OUT_VALID  output  1  OUT updated this cycle
 - ERR  output  1  last accepted op was invalid
 - LEDS  output  LED_WIDTH  error indicator

Function
REQ-006 Stage 1 SHALL register every input, including IN_VALID, on each rising clk edge.
REQ-007 Stage 2 SHALL compute only from stage-1 registers; no unregistered input reaches OUT, ERR, LEDS or OUT_VALID.
REQ-008 Latency: inputs presented with IN_VALID=1 before edge N SHALL produce OUT, ERR and OUT_VALID=1 after edge N+1.
REQ-009 When the registered IN_VALID=0, OUT, ERR and LEDS SHALL hold and OUT_VALID SHALL be 0.
REQ-010 Invalid op: OPCODE 6 or 7, or (RED_OP_A or RED_OP_B) with OPCODE not 0/1 -> OUT=0, ERR=1, LEDS inverted.
REQ-011 Invalid-op check SHALL take priority over bypass and over all opcodes.
REQ-012 Each further consecutive valid-qualified invalid op SHALL invert LEDS again (blink).
REQ-013 Any valid-qualified legal op SHALL clear ERR and set LEDS=0.
REQ-014 Bypass, second priority: with one select set, OUT = zero-extended selected operand; with both set, INPUT_PRIORITY picks A or B.
REQ-015 OPCODE 0: reduction AND of the selected operand (RED_OP select, INPUT_PRIORITY tie-break), else bitwise A&B; result zero-extended.
REQ-016 OPCODE 1: same selection as REQ-015 with XOR.
REQ-017 OPCODE 2: OUT = A+B(+CIN per FULL_ADDER), zero-extended, carry kept.
REQ-018 OPCODE 3: OUT = A*B, full 2*WIDTH product.
REQ-019 OPCODE 4: shift current OUT by 1; vacated bit = SERIAL_IN; left drops MSB, right drops LSB.
REQ-020 OPCODE 5: rotate current OUT by 1 across all 2*WIDTH bits in DIRECTION.
REQ-021 Shift and rotate SHALL use the OUT value held after the previous edge, including back-to-back issue.

Reset
REQ-022 rst=1 SHALL immediately clear all stage registers, OUT=0, OUT_VALID=0, ERR=0, LEDS=0, regardless of clk.
REQ-023 Reset mid-pipeline SHALL discard the in-flight op; no OUT_VALID pulse after release until a new IN_VALID=1 is accepted.

Verification (WIDTH=3, defaults)
REQ-024 A=5,B=3,OPCODE=2,CIN=1,IN_VALID=1 -> two edges later OUT=9, OUT_VALID=1, ERR=0.
REQ-025 A=7,B=7,OPCODE=3 -> OUT=49 (6'b110001); A=6,RED_OP_A=1,OPCODE=1 -> OUT=0.
REQ-026 OPCODE=6 held with IN_VALID=1 for 3 ops -> OUT=0, ERR=1, LEDS = FFFF, 0000, FFFF; next legal op -> LEDS=0, ERR=0.
REQ-027 BYPASSA=BYPASSB=1, A=2, B=5 -> OUT=2; rebuild with INPUT_PRIORITY="B" -> OUT=5.
REQ-028 OUT=6'b100001, OPCODE=5 DIRECTION=1 -> 6'b000011; then OPCODE=4 DIRECTION=0 SERIAL_IN=1 -> 6'b100001.
REQ-029 Assert rst between accept edge and result edge -> all outputs 0 at once, no OUT_VALID after release.
